// File: rtl/ip_bus_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ip_bus_initiator_pkg
// Brief    : Shared types and constants for the bus initiator and its FIFO.
// Revision : 1.0
// ============================================================================
package ip_bus_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  typedef struct packed {
    logic        write;
    logic        io;
    logic [15:0] address;
    logic [7:0]  wdata;
  } cmd_t;

  localparam logic [7:0] c_IDLE_DATA = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/ip_bus_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ip_bus_cmd_fifo
// Brief    : Power-of-two synchronous FIFO exposing full/empty and its head.
// Revision : 1.0
// ============================================================================
module ip_bus_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int             c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (push && !pop)      r_count <= r_count + 1'b1;
      else if (pop && !push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  assign head  = r_mem[r_rd_ptr];
  assign full  = (r_count == c_FULL);
  assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ip_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : ip_bus_initiator
// Brief    : Queues host read/write commands and runs them as Z80-style
//            strobed bus cycles. Read timeout enabled by BUS_INITIATOR_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module ip_bus_initiator
  import ip_bus_initiator_pkg::*;
#(
  parameter int         FIFO_DEPTH     = 4,
  parameter int         STROBE_CYCLES  = 2,
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_io,
  input  logic [15:0] cmd_address,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        mreq_n,
  output logic        iorq_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic [15:0] address,
  output logic [7:0]  wdata,
  input  logic [7:0]  rdata,
  input  logic        rdata_en,
  input  logic        wait_n
);

  // One counter serves both the write strobe length and the read timeout.
  localparam int c_STB_W = $clog2(STROBE_CYCLES + 1);
  localparam int c_CNT_W = (c_STB_W > $bits(TIMEOUT_CYCLES)) ? c_STB_W : $bits(TIMEOUT_CYCLES);

  state_t             r_state;
  state_t             w_state_nxt;
  cmd_t               r_cmd;
  cmd_t               w_head;
  cmd_t               w_push_cmd;
  logic [c_CNT_W-1:0] r_cnt;
  logic [7:0]         r_rdata;
  logic               r_rd_got;
  logic               r_timeout;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_cnt_run;
  logic               w_timeout_hit;
  logic               w_strobe_done;

  assign w_push_cmd = '{write: cmd_write, io: cmd_io, address: cmd_address, wdata: cmd_wdata};
  assign cmd_ready  = !w_full;
  assign w_push     = cmd_valid && cmd_ready;

  ip_bus_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_cmd),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

`ifdef BUS_INITIATOR_TIMEOUT_EN
  assign w_cnt_run     = wait_n && (r_cmd.write || (!rdata_en && !r_rd_got));
  assign w_timeout_hit = !r_cmd.write && wait_n && !rdata_en && !r_rd_got &&
                         (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 8'd1));
`else
  assign w_cnt_run     = wait_n && r_cmd.write;
  assign w_timeout_hit = 1'b0;
`endif

  // A read may see rdata_en while wait_n is low; the captured flag keeps it pending.
  assign w_strobe_done = r_cmd.write ? (wait_n && (r_cnt == c_CNT_W'(STROBE_CYCLES - 1)))
                                     : ((wait_n && (rdata_en || r_rd_got)) || w_timeout_hit);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP:  w_state_nxt = ST_STROBE;
      ST_STROBE: if (w_strobe_done) w_state_nxt = ST_HOLD;
      ST_HOLD:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd     <= '0;
      r_cnt     <= '0;
      r_rdata   <= c_IDLE_DATA;
      r_rd_got  <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_pop) begin
      r_cmd     <= w_head;
      r_cnt     <= '0;
      r_rdata   <= c_IDLE_DATA;
      r_rd_got  <= 1'b0;
      r_timeout <= 1'b0;
    end else if (r_state == ST_STROBE) begin
      if (!r_cmd.write && rdata_en && !r_rd_got) begin
        r_rdata  <= rdata;
        r_rd_got <= 1'b1;
      end
      if (w_cnt_run)     r_cnt     <= r_cnt + 1'b1;
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end

  always_comb begin
    mreq_n      = 1'b1;
    iorq_n      = 1'b1;
    rd_n        = 1'b1;
    wr_n        = 1'b1;
    rsp_valid   = 1'b0;
    rsp_rdata   = c_IDLE_DATA;
    rsp_timeout = 1'b0;
    if (r_state == ST_STROBE) begin
      if (r_cmd.io)    iorq_n = 1'b0;
      else             mreq_n = 1'b0;
      if (r_cmd.write) wr_n   = 1'b0;
      else             rd_n   = 1'b0;
    end
    if (r_state == ST_HOLD) begin
      rsp_valid   = 1'b1;
      rsp_rdata   = r_rdata;
      rsp_timeout = r_timeout;
    end
  end

  assign address = r_cmd.address;
  assign wdata   = r_cmd.wdata;
  assign busy    = !w_empty || (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ip_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_bus_initiator
// Brief    : Directed scoreboard bench for ip_bus_initiator with a bus responder.
// Revision : 1.0
// ============================================================================
module tb_ip_bus_initiator;

  localparam int         FIFO_DEPTH     = 4;
  localparam int         STROBE_CYCLES  = 2;
  localparam logic [7:0] TIMEOUT_CYCLES = 8'd8;

  typedef struct {
    logic [7:0] rd;
    logic       to;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic        cmd_io = 1'b0;
  logic [15:0] cmd_address = 16'h0;
  logic [7:0]  cmd_wdata = 8'h0;
  logic [7:0]  rdata = 8'h0;
  logic        rdata_en = 1'b0;
  logic        wait_n = 1'b1;
  logic        cmd_ready, rsp_valid, rsp_timeout, busy;
  logic        mreq_n, iorq_n, rd_n, wr_n;
  logic [7:0]  rsp_rdata, wdata;
  logic [15:0] address;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int push_cyc = 0;
  int fall_cyc = 0;
  int rsp_cyc = 0;
  int n_rsp = 0;
  int snap = 0;

  rsp_t        exp_rsp_q[$];
  logic [15:0] exp_addr_q[$];
  rsp_t        e;

  int          resp_delay = 2;
  logic [7:0]  resp_xor = 8'h3C;
  logic        in_strobe = 1'b0;
  logic        seen_strobe = 1'b0;
  int          lo_len = 0;
  int          hi_len = 0;
  logic [15:0] lo_addr = 16'h0;
  logic        lo_io = 1'b0, lo_wr = 1'b0, addr_stable = 1'b1;
  logic [7:0]  lo_wdata = 8'h0;
  int          last_len = 0;
  logic        last_io = 1'b0, last_wr = 1'b0, last_stable = 1'b0;
  logic [7:0]  last_wdata = 8'h0;

  ip_bus_initiator #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .STROBE_CYCLES  (STROBE_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_io      (cmd_io),
    .cmd_address (cmd_address),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .mreq_n      (mreq_n),
    .iorq_n      (iorq_n),
    .rd_n        (rd_n),
    .wr_n        (wr_n),
    .address     (address),
    .wdata       (wdata),
    .rdata       (rdata),
    .rdata_en    (rdata_en),
    .wait_n      (wait_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor, responder and response scoreboard, all sampled on the falling edge.
  always @(negedge clk) begin
    if (mreq_n === 1'b0 || iorq_n === 1'b0) begin
      if (!in_strobe) begin
        in_strobe   = 1'b1;
        lo_len      = 0;
        fall_cyc    = cyc;
        lo_addr     = address;
        lo_io       = (iorq_n === 1'b0);
        lo_wr       = (wr_n === 1'b0);
        lo_wdata    = wdata;
        addr_stable = 1'b1;
        if (seen_strobe) check("strobe_gap_ge3", 32'(hi_len >= 3), 32'd1);
        check("strobe_expected", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) check("strobe_address", 32'(address), 32'(exp_addr_q.pop_front()));
      end
      lo_len++;
      if (address !== lo_addr) addr_stable = 1'b0;
      check("space_onehot", 32'(mreq_n ^ iorq_n), 32'd1);
      check("dir_onehot", 32'(rd_n ^ wr_n), 32'd1);
      if (rd_n === 1'b0 && lo_len == resp_delay) begin
        rdata_en = 1'b1;
        rdata    = address[7:0] ^ resp_xor;
      end else begin
        rdata_en = 1'b0;
        rdata    = 8'h00;
      end
    end else begin
      if (in_strobe) begin
        in_strobe   = 1'b0;
        seen_strobe = 1'b1;
        hi_len      = 0;
        last_len    = lo_len;
        last_io     = lo_io;
        last_wr     = lo_wr;
        last_wdata  = lo_wdata;
        last_stable = addr_stable;
      end
      hi_len++;
      rdata_en = 1'b0;
      rdata    = 8'h00;
    end
    if (rsp_valid === 1'b1) begin
      rsp_cyc = cyc;
      n_rsp++;
      check("rsp_expected", 32'(exp_rsp_q.size() != 0), 32'd1);
      if (exp_rsp_q.size() != 0) begin
        e = exp_rsp_q.pop_front();
        check("rsp_rdata", 32'(rsp_rdata), 32'(e.rd));
        check("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
      end
    end
  end

  task automatic push(input logic wr, input logic io, input logic [15:0] a,
                      input logic [7:0] d, input logic [7:0] erd, input logic eto);
    int   n;
    rsp_t r;
    n = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_io = io; cmd_address = a; cmd_wdata = d;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("push_ready", 32'(cmd_ready), 32'd1);
    r.rd = erd;
    r.to = eto;
    exp_rsp_q.push_back(r);
    exp_addr_q.push_back(a);
    @(posedge clk); #1;
    push_cyc  = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_rsp_q.size() != 0) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_rsp_drained"}, 32'(exp_rsp_q.size()), 32'd0);
  endtask

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    while (!in_strobe && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_strobe_seen"}, 32'(in_strobe), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_strobes", 32'({mreq_n, iorq_n, rd_n, wr_n}), 32'hF);
    check("rst_address", 32'(address), 32'h0000);
    check("rst_wdata", 32'(wdata), 32'h00);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'hFF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Memory write C012h <- 5Ah with exact cycle timing.
    push(1'b1, 1'b0, 16'hC012, 8'h5A, 8'hFF, 1'b0);
    wait_idle("mem_wr");
    check("mem_wr_len", 32'(last_len), 32'(STROBE_CYCLES));
    check("mem_wr_is_mem", 32'(last_io), 32'd0);
    check("mem_wr_is_wr", 32'(last_wr), 32'd1);
    check("mem_wr_wdata", 32'(last_wdata), 32'h5A);
    check("mem_wr_fall_lat", 32'(fall_cyc - push_cyc), 32'd2);
    check("mem_wr_rsp_lat", 32'(rsp_cyc - push_cyc), 32'(2 + STROBE_CYCLES));

    // I/O read 10h, data on 2nd strobe cycle.
    resp_delay = 2; resp_xor = 8'h13;
    push(1'b0, 1'b1, 16'h0010, 8'h00, 8'h03, 1'b0);
    wait_idle("io_rd");
    check("io_rd_len", 32'(last_len), 32'd2);
    check("io_rd_is_io", 32'(last_io), 32'd1);
    check("io_rd_is_rd", 32'(last_wr), 32'd0);
    check("io_rd_rsp_lat", 32'(rsp_cyc - fall_cyc), 32'd2);

    // Reads answered on the 1st and 3rd strobe cycles.
    resp_xor = 8'h3C;
    resp_delay = 1;
    push(1'b0, 1'b0, 16'h00F0, 8'h00, 8'hCC, 1'b0);
    wait_idle("rd_k1");
    check("rd_k1_len", 32'(last_len), 32'd1);
    resp_delay = 3;
    push(1'b0, 1'b0, 16'h1234, 8'h00, 8'h08, 1'b0);
    wait_idle("rd_k3");
    check("rd_k3_len", 32'(last_len), 32'd3);

    // FIFO fill: first command stalled in STROBE, then five pushed back-to-back.
    resp_delay = 2;
    wait_n = 1'b0;
    push(1'b1, 1'b0, 16'h2000, 8'hAA, 8'hFF, 1'b0);
    wait_strobe("fill");
    push(1'b0, 1'b0, 16'h0101, 8'h00, 8'h3D, 1'b0);
    push(1'b1, 1'b1, 16'h0042, 8'h77, 8'hFF, 1'b0);
    push(1'b0, 1'b1, 16'h0055, 8'h00, 8'h69, 1'b0);
    push(1'b1, 1'b0, 16'h3003, 8'h12, 8'hFF, 1'b0);
    check("fill_ready_low", 32'(cmd_ready), 32'd0);
    check("fill_busy", 32'(busy), 32'd1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_io = 1'b0; cmd_address = 16'h0707;
    @(posedge clk); #1;
    check("fill_ready_held_low", 32'(cmd_ready), 32'd0);
    snap = n_rsp;
    wait_n = 1'b1;
    push(1'b0, 1'b0, 16'h0707, 8'h00, 8'h3B, 1'b0);
    wait_idle("fill");
    check("fill_rsp_count", 32'(n_rsp - snap), 32'd6);

    // wait_n low for 3 cycles during a write stretches the strobe.
    push(1'b1, 1'b0, 16'h5555, 8'h11, 8'hFF, 1'b0);
    wait_strobe("wait");
    wait_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 wait_n = 1'b1;
    wait_idle("wait");
    check("wait_len", 32'(last_len), 32'(STROBE_CYCLES + 3));
    check("wait_addr_stable", 32'(last_stable), 32'd1);

`ifdef BUS_INITIATOR_TIMEOUT_EN
    resp_delay = 0;
    push(1'b0, 1'b0, 16'h8000, 8'h00, 8'hFF, 1'b1);
    wait_idle("tmo");
    check("tmo_len", 32'(last_len), 32'(TIMEOUT_CYCLES));
    resp_delay = 2;
`endif

    // Reset during STROBE with two commands queued.
    wait_n = 1'b0;
    push(1'b1, 1'b0, 16'h4444, 8'h44, 8'hFF, 1'b0);
    wait_strobe("rst_mid");
    push(1'b1, 1'b0, 16'h4545, 8'h45, 8'hFF, 1'b0);
    push(1'b0, 1'b0, 16'h4646, 8'h00, 8'h7A, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_rsp_q.delete();
    exp_addr_q.delete();
    check("rst_mid_strobes", 32'({mreq_n, iorq_n, rd_n, wr_n}), 32'hF);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ready", 32'(cmd_ready), 32'd1);
    wait_n = 1'b1;
    snap = n_rsp;
    repeat (20) @(posedge clk);
    #1;
    check("rst_mid_no_rsp", 32'(n_rsp - snap), 32'd0);
    check("rst_mid_still_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ip_bus_initiator.md
# ip_bus_initiator

Z80-style bus initiator: drives the same 8-bit memory/I/O bus that the GPIO, ROM, RAM and video responders decode. It takes single-byte read/write commands from a host-side port (debug bridge, boot loader, test sequencer), buffers them, and runs them as bus cycles with `mreq_n`/`iorq_n`/`rd_n`/`wr_n` strobes. It collects `rdata_en`/`rdata` from responders and returns one response per command. It sits beside the CPU core as an alternate bus owner; bus arbitration is outside this block.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; must be a power of two, 2..16.
- `STROBE_CYCLES`, 2: minimum number of cycles a strobe stays low; must be ≥1.
- `TIMEOUT_CYCLES`, 255: read-timeout limit in cycles, 8-bit; only used under the timeout macro.
- `clk`  in  1  single clock for the whole block (`clk_pixel` domain).
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_io`  in  1  1 = I/O cycle (`iorq_n`), 0 = memory cycle (`mreq_n`).
- `cmd_address`  in  16  bus address.
- `cmd_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle response pulse; no backpressure.
- `rsp_rdata`  out  8  read data; FFh for writes and for timeouts.
- `rsp_timeout`  out  1  valid with `rsp_valid`; set when the read timed out.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.
- `mreq_n`, `iorq_n`, `rd_n`, `wr_n`  out  1 each  bus strobes, active-low.
- `address`  out  16  bus address.
- `wdata`  out  8  bus write data.
- `rdata`  in  8  responder read data (responder outputs ORed or muxed externally).
- `rdata_en`  in  1  responder data-valid pulse.
- `wait_n`  in  1  active-low cycle stretch.

## Operation
- Reset values:
  - `mreq_n`, `iorq_n`, `rd_n`, `wr_n` = 1.
  - `address` = 0000h, `wdata` = 00h.
  - `rsp_valid` = 0, `rsp_timeout` = 0, `rsp_rdata` = FFh, `busy` = 0.
  - FIFO empty, so `cmd_ready` = 1.
- A command is pushed when `cmd_valid && cmd_ready`. A push while full is impossible by the handshake. Push and pop in the same cycle are both allowed, and the count is unchanged.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head, register `address`/`wdata`/type, and go to SETUP.
  - SETUP: 1 cycle; address and data are driven, strobes stay high; go to STROBE.
  - STROBE:
    - Drive `mreq_n` or `iorq_n` low (never both) together with `rd_n` or `wr_n` low (never both).
    - Write: leave after `STROBE_CYCLES` cycles; the strobe is extended while `wait_n` = 0.
    - Read: capture `rdata` on the first cycle with `rdata_en` = 1, then leave. `rdata_en` is ignored before the strobe goes low. `wait_n` = 0 blocks the exit.
  - HOLD: 1 cycle; strobes high, address held; assert `rsp_valid` with the results; go to IDLE.
- Outside STROBE, `rdata_en` is ignored.
- A mid-operation `reset` returns the FSM to IDLE, raises all strobes on the next edge, flushes the FIFO, and emits no response.

## Timing
- Write pushed on edge E with the FIFO empty and the FSM in IDLE:
  - The pop happens on edge E+1.
  - Strobes are low from edge E+2 through edge E+2+`STROBE_CYCLES`.
  - `rsp_valid` is high for the one cycle after that edge.
- Read: the strobe falls on edge E+2. With `rdata_en` seen at edge E+2+k, the strobe rises and `rsp_valid` is high in the cycle after edge E+2+k.
- Back-to-back commands: a new SETUP starts on the edge after HOLD. Consecutive strobes are separated by at least 3 high cycles (HOLD, IDLE, SETUP).
- `cmd_ready` is combinational from the FIFO count only.

## Configuration
- `BUS_INITIATOR_TIMEOUT_EN` defined:
  - An 8-bit counter runs during a read STROBE, and only while `wait_n` = 1.
  - When it reaches `TIMEOUT_CYCLES` without `rdata_en`, go to HOLD with `rsp_rdata` = FFh and `rsp_timeout` = 1.
- Not defined: reads wait indefinitely for `rdata_en`, the counter logic is absent, and `rsp_timeout` is tied to 0.

## Structure
- Shared package `ip_bus_initiator_pkg`:
  - State enum (IDLE, SETUP, STROBE, HOLD).
  - Command struct {write, io, address[15:0], wdata[7:0]}, 26 bits.
  - Idle data constant FFh.
- Sub-module `ip_bus_cmd_fifo`:
  - Synchronous FIFO parameterised by depth and width.
  - Outputs full/empty/head.
  - Synchronous active-high reset.

## Test plan
- Memory write C012h←5Ah, `STROBE_CYCLES` = 2, `wait_n` = 1 → `mreq_n` and `wr_n` low for exactly 2 cycles with `address` = C012h and `wdata` = 5Ah; `iorq_n` stays high; one `rsp_valid` with `rsp_rdata` = FFh.
- I/O read 10h, responder pulses `rdata_en` with 03h on the 2nd strobe cycle → `iorq_n` and `rd_n` low for 2 cycles; `rsp_rdata` = 03h, `rsp_timeout` = 0.
- Five commands pushed back-to-back, `FIFO_DEPTH` = 4 → `cmd_ready` drops after the 4th push; all five execute in order; five responses.
- `wait_n` held 0 for 3 cycles during a write → strobe low for 2+3 cycles; address stable throughout.
- With the macro, `TIMEOUT_CYCLES` = 8, no `rdata_en` → strobe released after 8 cycles; `rsp_timeout` = 1, `rsp_rdata` = FFh.
- `reset` asserted during STROBE with 2 commands queued → strobes high on the next edge; `busy` = 0; no `rsp_valid` afterwards.
